// File: rtl/core88_pkg.sv
// -----------------------------------------------------------------------------
// core88_pkg
// Constants and small helpers shared by the core88 memory-side blocks.
//  - Segment/offset/linear-address widths of the core88 address model.
//  - Encoding of the byte-serial sequencer states (IDLE/ACCESS/DONE).
//  - Offset helpers for the start and end offsets of a transfer.
// -----------------------------------------------------------------------------
package core88_pkg;

    // A segment is placed on a 16-byte boundary of the linear space.
    localparam int SEG_SHIFT = 4;
    localparam int ADDR_W    = 20;
    localparam int OFF_W     = 16;

    // Sequencer state encoding, shared with the execution FSM.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Offset of byte 0. A stack write pushes below SP, so it starts count
    // bytes lower; every other access starts at the given offset.
    function automatic logic [OFF_W-1:0] first_offset(
        input logic [OFF_W-1:0] off,
        input logic [OFF_W-1:0] count,
        input logic             stack_write
    );
        logic [OFF_W-1:0] res;
        if (stack_write) begin
            res = off - count;
        end else begin
            res = off;
        end
        return res;
    endfunction

    // Offset reported after the transfer. For a stack write this is the new
    // SP (the lowest byte written); otherwise it is one past the last byte.
    // Arithmetic is 16-bit, so it wraps inside the segment.
    function automatic logic [OFF_W-1:0] final_offset(
        input logic [OFF_W-1:0] off,
        input logic [OFF_W-1:0] count,
        input logic             stack_write
    );
        logic [OFF_W-1:0] res;
        if (stack_write) begin
            res = off - count;
        end else begin
            res = off + count;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_addr_gen.sv
// -----------------------------------------------------------------------------
// seg_addr_gen
// Combinational segment:offset to linear address translation.
//  seg    in  16  segment
//  off    in  16  offset inside the segment
//  linear out 20  (seg << 4) + off, carry out of bit 19 dropped (A20 wrap)
// -----------------------------------------------------------------------------
module seg_addr_gen
    import core88_pkg::*;
(
    input  logic [OFF_W-1:0]  seg,
    input  logic [OFF_W-1:0]  off,
    output logic [ADDR_W-1:0] linear
);

    logic [ADDR_W-1:0] seg_base_s;
    logic [ADDR_W-1:0] off_ext_s;

    // Sum truncated to 20 bits so FFFF:0010 lands on linear 00000.
    always_comb begin
        seg_base_s = {seg, {SEG_SHIFT{1'b0}}};
        off_ext_s  = {{(ADDR_W - OFF_W){1'b0}}, off};
        linear     = seg_base_s + off_ext_s;
    end

endmodule

// File: rtl/bus_seq88.sv
// -----------------------------------------------------------------------------
// bus_seq88
// Byte-serial memory access sequencer. One accepted request (segment, offset,
// 1..MAX_BYTES bytes, read/write, normal/stack) becomes consecutive 8-bit bus
// slots of 1+WAIT cycles each; read bytes are assembled little-endian.
//  clock, reset        clock and asynchronous active-high reset
//  locked              clock enable; low freezes every register
//  req_valid/ready     request handshake, ready only while idle
//  req_we, req_stack   direction and stack mode (push pre-decrements)
//  req_size            byte count minus one
//  req_seg, req_off    start segment and offset (SP in stack mode)
//  req_wdata           write bytes, byte 0 in the low bits
//  rsp_valid           one-cycle completion pulse
//  rsp_rdata           last read result, bytes above size zero
//  rsp_off_next        offset after the transfer (new SP in stack mode)
//  address, data, wreq 8-bit memory port (registered); bus is read data
// -----------------------------------------------------------------------------
module bus_seq88
    import core88_pkg::*;
#(
    parameter int MAX_BYTES = 4,
    parameter int WAIT      = 0
)(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         locked,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic                         req_stack,
    input  logic [$clog2(MAX_BYTES)-1:0] req_size,
    input  logic [OFF_W-1:0]             req_seg,
    input  logic [OFF_W-1:0]             req_off,
    input  logic [8*MAX_BYTES-1:0]       req_wdata,
    output logic                         rsp_valid,
    output logic [8*MAX_BYTES-1:0]       rsp_rdata,
    output logic [OFF_W-1:0]             rsp_off_next,
    output logic [ADDR_W-1:0]            address,
    input  logic [7:0]                   bus,
    output logic [7:0]                   data,
    output logic                         wreq
);

    localparam int SZ_W = $clog2(MAX_BYTES);
    localparam int DW   = 8 * MAX_BYTES;
    // The wait counter needs at least one bit even when WAIT is zero.
    localparam int WC_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT);

    // Control state
    logic [1:0]        state_r;
    logic [SZ_W-1:0]   byte_cnt_r;
    logic [WC_W-1:0]   wait_cnt_r;

    // Request captured at accept
    logic [OFF_W-1:0]  seg_r;
    logic [SZ_W-1:0]   size_r;
    logic              we_r;
    logic [OFF_W-1:0]  off_cur_r;
    logic [OFF_W-1:0]  off_next_r;
    logic [DW-1:0]     wdata_r;

    // Datapath / outputs
    logic [DW-1:0]     rdata_acc_r;
    logic [DW-1:0]     rsp_rdata_r;
    logic [OFF_W-1:0]  rsp_off_next_r;
    logic              rsp_valid_r;
    logic [ADDR_W-1:0] address_r;
    logic [7:0]        data_r;
    logic              wreq_r;

    // Combinational helpers
    logic              accept_s;
    logic              slot_end_s;
    logic              last_byte_s;
    logic [OFF_W-1:0]  count_s;
    logic [OFF_W-1:0]  start_off_s;
    logic [OFF_W-1:0]  end_off_s;
    logic [OFF_W-1:0]  gen_seg_s;
    logic [OFF_W-1:0]  gen_off_s;
    logic [ADDR_W-1:0] gen_linear_s;
    logic [DW-1:0]     acc_next_s;
    logic [DW-1:0]     wdata_shift_s;

    // Accept/slot decode and the offsets of a new request.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && req_valid && locked;
        slot_end_s  = (state_r == ST_ACCESS) && (wait_cnt_r == WAIT_LAST);
        last_byte_s = (byte_cnt_r == size_r);
        count_s     = {{(OFF_W - SZ_W){1'b0}}, req_size} + 16'd1;
        start_off_s = first_offset(req_off, count_s, req_we && req_stack);
        end_off_s   = final_offset(req_off, count_s, req_we && req_stack);
    end

    // The address generator serves byte 0 while idle (ready for accept) and
    // the next byte while a transfer runs; the offset wraps at 16 bits.
    always_comb begin
        if (state_r == ST_IDLE) begin
            gen_seg_s = req_seg;
            gen_off_s = start_off_s;
        end else begin
            gen_seg_s = seg_r;
            gen_off_s = off_cur_r + 16'd1;
        end
    end

    seg_addr_gen u_seg_addr_gen (
        .seg    (gen_seg_s),
        .off    (gen_off_s),
        .linear (gen_linear_s)
    );

    // Insert the bus byte into the read accumulator and pre-shift write data.
    always_comb begin
        acc_next_s = rdata_acc_r;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (byte_cnt_r == SZ_W'(i)) begin
                acc_next_s[i*8 +: 8] = bus;
            end else begin
                acc_next_s[i*8 +: 8] = rdata_acc_r[i*8 +: 8];
            end
        end
        wdata_shift_s = {8'h00, wdata_r[DW-1:8]};
    end

    // FSM, byte counter and wait counter; nothing moves while locked is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= {SZ_W{1'b0}};
            wait_cnt_r <= {WC_W{1'b0}};
        end else if (locked) begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_r    <= ST_ACCESS;
                        byte_cnt_r <= {SZ_W{1'b0}};
                        wait_cnt_r <= {WC_W{1'b0}};
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (slot_end_s) begin
                        wait_cnt_r <= {WC_W{1'b0}};
                        if (last_byte_s) begin
                            state_r    <= ST_DONE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + SZ_W'(1);
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WC_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Request capture and memory-port outputs. address/data/wreq are loaded
    // at accept for byte 0 and at each slot end for the following byte, so
    // they stay stable for the whole slot; wreq drops when the last slot ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_r      <= 16'h0000;
            size_r     <= {SZ_W{1'b0}};
            we_r       <= 1'b0;
            off_cur_r  <= 16'h0000;
            off_next_r <= 16'h0000;
            wdata_r    <= {DW{1'b0}};
            address_r  <= 20'h00000;
            data_r     <= 8'h00;
            wreq_r     <= 1'b0;
        end else if (locked) begin
            if (accept_s) begin
                seg_r      <= req_seg;
                size_r     <= req_size;
                we_r       <= req_we;
                off_cur_r  <= start_off_s;
                off_next_r <= end_off_s;
                wdata_r    <= {8'h00, req_wdata[DW-1:8]};
                address_r  <= gen_linear_s;
                data_r     <= req_we ? req_wdata[7:0] : 8'h00;
                wreq_r     <= req_we;
            end else if (slot_end_s) begin
                if (last_byte_s) begin
                    wreq_r    <= 1'b0;
                end else begin
                    off_cur_r <= off_cur_r + 16'd1;
                    wdata_r   <= wdata_shift_s;
                    address_r <= gen_linear_s;
                    data_r    <= we_r ? wdata_r[7:0] : 8'h00;
                end
            end
        end
    end

    // Read assembly and response. The accumulator is cleared at accept so
    // bytes above the transfer size read as zero; writes keep rsp_rdata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_acc_r    <= {DW{1'b0}};
            rsp_rdata_r    <= {DW{1'b0}};
            rsp_off_next_r <= 16'h0000;
            rsp_valid_r    <= 1'b0;
        end else if (locked) begin
            rsp_valid_r <= slot_end_s && last_byte_s;
            if (accept_s) begin
                rdata_acc_r <= {DW{1'b0}};
            end else if (slot_end_s) begin
                if (!we_r) begin
                    rdata_acc_r <= acc_next_s;
                end
                if (last_byte_s) begin
                    rsp_off_next_r <= off_next_r;
                    if (!we_r) begin
                        rsp_rdata_r <= acc_next_s;
                    end
                end
            end
        end
    end

    assign req_ready    = (state_r == ST_IDLE);
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign rsp_off_next = rsp_off_next_r;
    assign address      = address_r;
    assign data         = data_r;
    assign wreq         = wreq_r;

endmodule
